// File: rtl/fifo_single_clock_programmable_pkg.sv
// Shared helpers for the single-clock FIFO library: width math and saturating arithmetic.
package fifo_single_clock_programmable_pkg;

  // Smallest w such that 2**w >= n (n = 0 or 1 gives 0).
  function automatic int clog2_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // Occupancy needs one bit more than the pointers so that 0..DEPTH all fit.
  function automatic int count_width(input int log2_depth);
    return log2_depth + 1;
  endfunction

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
    return (value == max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_single_clock_programmable_if.sv
// Producer/consumer-facing signal bundle of the programmable FIFO.
interface fifo_single_clock_programmable_if #(
  parameter int DATA_WIDTH          = 8,
  parameter int LOG2_OF_DEPTH       = 4,
  parameter int ERROR_COUNTER_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]          data_in;
  logic                           write_enable;
  logic                           read_enable;
  logic [DATA_WIDTH-1:0]          data_out;
  logic                           full;
  logic                           empty;
  logic                           almost_full;
  logic                           almost_empty;
  logic [LOG2_OF_DEPTH:0]         almost_full_threshold;
  logic [LOG2_OF_DEPTH:0]         almost_empty_threshold;
  logic [LOG2_OF_DEPTH:0]         count;
  logic                           overflow;
  logic                           underflow;
  logic                           clear_errors;
  logic [ERROR_COUNTER_WIDTH-1:0] write_error_count;
  logic [ERROR_COUNTER_WIDTH-1:0] read_error_count;

  modport master (
    output data_in, write_enable, read_enable, almost_full_threshold,
           almost_empty_threshold, clear_errors,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow, write_error_count, read_error_count
  );

  modport slave (
    input  data_in, write_enable, read_enable, almost_full_threshold,
           almost_empty_threshold, clear_errors,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow, write_error_count, read_error_count
  );
endinterface

// File: rtl/fifo_single_clock_programmable_saturating_error_counter.sv
// Saturating event counter with a synchronous clear that dominates the increment.
module fifo_saturating_error_counter
  import fifo_single_clock_programmable_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             increment,
  input  logic             clear,
  output logic [WIDTH-1:0] value
);
  logic [WIDTH-1:0] value_q, value_d;

  // Next value: clear first, otherwise count up and stick at all-ones.
  always_comb begin
    value_d = value_q;
    if (clear) value_d = '0;
    else if (increment) value_d = WIDTH'(sat_inc(32'(value_q), 32'({WIDTH{1'b1}})));
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value = value_q;
endmodule

// File: rtl/fifo_single_clock_programmable.sv
// Single-clock FIFO, all DEPTH entries usable, with programmable almost flags,
// FWFT or registered read, and overflow/underflow reporting.
module fifo_single_clock_programmable
  import fifo_single_clock_programmable_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int LOG2_OF_DEPTH       = 4,
  parameter int FWFT                = 1,
  parameter int ERROR_COUNTER_WIDTH = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  fifo_single_clock_programmable_if.slave bus
);
  localparam int DEPTH       = 1 << LOG2_OF_DEPTH;
  localparam int COUNT_WIDTH = count_width(LOG2_OF_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [LOG2_OF_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic                     overflow_q, overflow_d, underflow_q, underflow_d;
  logic                     full, empty, wr_acc, rd_acc;

  // Flags derive from count only, so pointer equality never needs disambiguating.
  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  assign wr_acc = bus.write_enable && !full;
  assign rd_acc = bus.read_enable && !empty;

  // Pointer, occupancy and error-pulse next state.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = bus.write_enable && full;
    underflow_d = bus.read_enable && empty;
    if (wr_acc) wr_ptr_d = wr_ptr_q + LOG2_OF_DEPTH'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + LOG2_OF_DEPTH'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + COUNT_WIDTH'(1);
      2'b01:   count_d = count_q - COUNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers; storage is deliberately left out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clock) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown directly; masked while empty so stale storage never leaks.
      assign bus.data_out = empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] dout_q, dout_d;

      // Output register loads only on an accepted read.
      always_comb begin
        dout_d = dout_q;
        if (rd_acc) dout_d = mem_q[rd_ptr_q];
      end

      // Output register.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) dout_q <= '0;
        else       dout_q <= dout_d;
      end

      assign bus.data_out = dout_q;
    end
  endgenerate

  fifo_saturating_error_counter #(.WIDTH(ERROR_COUNTER_WIDTH)) u_write_errors (
    .clock     (clock),
    .reset     (reset),
    .increment (overflow_d),
    .clear     (bus.clear_errors),
    .value     (bus.write_error_count)
  );

  fifo_saturating_error_counter #(.WIDTH(ERROR_COUNTER_WIDTH)) u_read_errors (
    .clock     (clock),
    .reset     (reset),
    .increment (underflow_d),
    .clear     (bus.clear_errors),
    .value     (bus.read_error_count)
  );

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= bus.almost_full_threshold);
  assign bus.almost_empty = (count_q <= bus.almost_empty_threshold);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
